// File: rtl/jtframe_paddle_multi.sv
// Multi-channel mouse-to-paddle converter: integrates signed mouse deltas into
// absolute paddle positions and emits spaced step/direction dial pulses.
module jtframe_paddle_multi #(
    parameter int CH     = 2,
    parameter int DW     = 9,
    parameter int PW     = 8,
    parameter int PMAX   = 255,
    parameter int CENTRE = 128,
    parameter int SENS   = 0,
    parameter int WRAP   = 0,
    parameter int PEND_W = 6,
    parameter int GAP    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH*DW-1:0] mouse_dx,
    input  logic             mouse_st,
    input  logic             recentre,
    output logic [CH*PW-1:0] paddle,
    output logic [CH-1:0]    dial_pulse,
    output logic [CH-1:0]    dial_dir
);

    localparam int AW    = DW + SENS + 1;
    localparam int FW    = (SENS > 0) ? SENS : 1;
    localparam int NW    = PW + AW + 1;
    localparam int PS    = ((PEND_W > AW) ? PEND_W : AW) + 2;
    localparam int GW    = $clog2(GAP);
    localparam int NITER = (2 ** DW) / (PMAX + 1) + 2;
    localparam int PLIM  = 2 ** (PEND_W - 1) - 1;

    localparam logic signed [NW-1:0]     PMAX_N     = NW'(PMAX);
    localparam logic signed [NW-1:0]     MOD_N      = NW'(PMAX + 1);
    localparam logic [PW-1:0]            PMAX_P     = PW'(PMAX);
    localparam logic [PW-1:0]            CENTRE_P   = PW'(CENTRE);
    localparam logic signed [PS-1:0]     PLIM_S     = PS'(PLIM);
    localparam logic signed [PS-1:0]     ONE_S      = PS'(1);
    localparam logic signed [PEND_W-1:0] PLIM_P     = PEND_W'(PLIM);
    localparam logic [GW-1:0]            GAP_RELOAD = GW'(GAP - 1);
    localparam logic [GW-1:0]            GAP_ONE    = GW'(1);

    // mouse_st and recentre are single-cycle strobes with no back-pressure:
    // a strobe is consumed on the edge that samples it, and recentre wins.
    for (genvar n = 0; n < CH; n++) begin : g_ch
        logic [PW-1:0]            pad_q, pad_d;
        logic [FW-1:0]            frac_q, frac_d;
        logic signed [PEND_W-1:0] pend_q, pend_d;
        logic [GW-1:0]            gap_q, gap_d;
        logic                     pulse_q, pulse_d;
        logic                     dir_q, dir_d;

        logic signed [DW-1:0]     dx;
        logic signed [AW-1:0]     acc;
        logic signed [AW-1:0]     step;
        logic [FW-1:0]            frac_nx;
        logic signed [NW-1:0]     nx;
        logic signed [NW-1:0]     wr;
        logic [PW-1:0]            pos_clamp;
        logic [PW-1:0]            pos_nx;
        logic                     fire;
        logic signed [PS-1:0]     add_step;
        logic signed [PS-1:0]     add_fire;
        logic signed [PS-1:0]     psum;

        assign dx = mouse_dx[n*DW +: DW];

        always_comb begin
            acc     = $signed({{(AW-DW){dx[DW-1]}}, dx}) + $signed({{(AW-FW){1'b0}}, frac_q});
            step    = acc >>> SENS;
            frac_nx = (SENS > 0) ? acc[FW-1:0] : '0;
            nx      = $signed({{(NW-PW){1'b0}}, pad_q}) + $signed({{(NW-AW){step[AW-1]}}, step});

            if (nx[NW-1])
                pos_clamp = '0;
            else if (nx > PMAX_N)
                pos_clamp = PMAX_P;
            else
                pos_clamp = nx[PW-1:0];

            // Bounded reduction: NITER covers the largest possible |step|.
            wr = nx;
            for (int i = 0; i < NITER; i++) begin
                if (wr >= MOD_N)
                    wr = wr - MOD_N;
                else if (wr[NW-1])
                    wr = wr + MOD_N;
            end
            pos_nx = (WRAP != 0) ? wr[PW-1:0] : pos_clamp;

            fire     = (gap_q == '0) && (pend_q != '0);
            add_step = mouse_st ? $signed({{(PS-AW){step[AW-1]}}, step}) : '0;
            add_fire = fire ? (pend_q[PEND_W-1] ? -ONE_S : ONE_S) : '0;
            psum     = $signed({{(PS-PEND_W){pend_q[PEND_W-1]}}, pend_q}) + add_step - add_fire;

            pad_d  = pad_q;
            frac_d = frac_q;
            dir_d  = dir_q;
            if (psum > PLIM_S)
                pend_d = PLIM_P;
            else if (psum < -PLIM_S)
                pend_d = -PLIM_P;
            else
                pend_d = psum[PEND_W-1:0];

            if (fire) begin
                pulse_d = 1'b1;
                dir_d   = ~pend_q[PEND_W-1];
                gap_d   = GAP_RELOAD;
            end else begin
                pulse_d = 1'b0;
                gap_d   = (gap_q == '0) ? '0 : gap_q - GAP_ONE;
            end

            if (mouse_st) begin
                pad_d  = pos_nx;
                frac_d = frac_nx;
            end

            if (recentre) begin
                pad_d   = CENTRE_P;
                frac_d  = '0;
                pend_d  = '0;
                gap_d   = '0;
                pulse_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pad_q   <= CENTRE_P;
                frac_q  <= '0;
                pend_q  <= '0;
                gap_q   <= '0;
                pulse_q <= 1'b0;
                dir_q   <= 1'b0;
            end else begin
                pad_q   <= pad_d;
                frac_q  <= frac_d;
                pend_q  <= pend_d;
                gap_q   <= gap_d;
                pulse_q <= pulse_d;
                dir_q   <= dir_d;
            end
        end

        assign paddle[n*PW +: PW] = pad_q;
        assign dial_pulse[n]      = pulse_q;
        assign dial_dir[n]        = dir_q;
    end

endmodule

// File: tb/tb_jtframe_paddle_multi.sv
// Directed bench for jtframe_paddle_multi: four parameterisations sharing one
// clock, reset, strobe and recentre; each exercises one feature.
module tb_jtframe_paddle_multi;

    logic        clk;
    logic        rst_n;
    logic        mouse_st;
    logic        recentre;
    logic [17:0] dx_a, dx_b, dx_c, dx_d;
    logic [15:0] pad_a, pad_b, pad_c, pad_d;
    logic [1:0]  pul_a, pul_b, pul_c, pul_d;
    logic [1:0]  dir_a, dir_b, dir_c, dir_d;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cnt;
    int          neg;
    logic [15:0] seen;
    logic        other;

    // u_a: sensitivity, u_b: clamp, u_c: wrap, u_d: dial / recentre / reset
    jtframe_paddle_multi #(.CH(2), .DW(9), .PW(8), .PMAX(200), .CENTRE(100), .SENS(2),
        .WRAP(0), .PEND_W(6), .GAP(4)) u_a (
        .clk(clk), .rst_n(rst_n), .mouse_dx(dx_a), .mouse_st(mouse_st), .recentre(recentre),
        .paddle(pad_a), .dial_pulse(pul_a), .dial_dir(dir_a));

    jtframe_paddle_multi #(.CH(2), .DW(9), .PW(8), .PMAX(200), .CENTRE(100), .SENS(0),
        .WRAP(0), .PEND_W(6), .GAP(4)) u_b (
        .clk(clk), .rst_n(rst_n), .mouse_dx(dx_b), .mouse_st(mouse_st), .recentre(recentre),
        .paddle(pad_b), .dial_pulse(pul_b), .dial_dir(dir_b));

    jtframe_paddle_multi #(.CH(2), .DW(9), .PW(8), .PMAX(199), .CENTRE(100), .SENS(0),
        .WRAP(1), .PEND_W(6), .GAP(4)) u_c (
        .clk(clk), .rst_n(rst_n), .mouse_dx(dx_c), .mouse_st(mouse_st), .recentre(recentre),
        .paddle(pad_c), .dial_pulse(pul_c), .dial_dir(dir_c));

    jtframe_paddle_multi #(.CH(2), .DW(9), .PW(8), .PMAX(200), .CENTRE(100), .SENS(0),
        .WRAP(0), .PEND_W(6), .GAP(4)) u_d (
        .clk(clk), .rst_n(rst_n), .mouse_dx(dx_d), .mouse_st(mouse_st), .recentre(recentre),
        .paddle(pad_d), .dial_pulse(pul_d), .dial_dir(dir_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] pack(input int c0, input int c1);
        logic [8:0] a;
        logic [8:0] b;
        a = c0[8:0];
        b = c1[8:0];
        return {b, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe();
        mouse_st = 1'b1;
        tick();
        mouse_st = 1'b0;
        dx_a = '0;
        dx_b = '0;
        dx_c = '0;
        dx_d = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        rst_n    = 1'b0;
        mouse_st = 1'b0;
        recentre = 1'b0;
        dx_a = '0;
        dx_b = '0;
        dx_c = '0;
        dx_d = '0;

        // reset values
        repeat (3) tick();
        check("rst_pad0", 32'(pad_a[7:0]), 100);
        check("rst_pad1", 32'(pad_a[15:8]), 100);
        check("rst_pulse", 32'(pul_a), 0);
        check("rst_dir", 32'(dir_a), 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_pad", 32'(pad_a), 32'h6464);

        // sensitivity shift of 2 with fractional carry
        dx_a = pack(3, 0);
        strobe();
        check("sens_s1_pad0", 32'(pad_a[7:0]), 100);
        dx_a = pack(3, 0);
        strobe();
        check("sens_s2_pad0", 32'(pad_a[7:0]), 101);
        dx_a = pack(3, 0);
        strobe();
        check("sens_s3_pad0", 32'(pad_a[7:0]), 102);
        check("sens_s3_pad1", 32'(pad_a[15:8]), 100);
        dx_a = pack(-3, 0);
        strobe();
        check("sens_neg_pad0", 32'(pad_a[7:0]), 101);

        // clamp
        dx_b = pack(255, -5);
        strobe();
        check("clamp_hi1", 32'(pad_b[7:0]), 200);
        check("clamp_ch1", 32'(pad_b[15:8]), 95);
        dx_b = pack(255, 0);
        strobe();
        repeat (3) tick();
        check("clamp_hold", 32'(pad_b[7:0]), 200);
        dx_b = pack(-256, 0);
        strobe();
        check("clamp_lo", 32'(pad_b[7:0]), 0);
        dx_b = pack(-1, 0);
        strobe();
        check("clamp_lo_hold", 32'(pad_b[7:0]), 0);
        check("clamp_ch1_hold", 32'(pad_b[15:8]), 95);

        // wrap modulo 200
        dx_c = pack(150, -256);
        strobe();
        check("wrap_p150", 32'(pad_c[7:0]), 50);
        check("wrap_m256a", 32'(pad_c[15:8]), 44);
        dx_c = pack(-60, -256);
        strobe();
        check("wrap_m60", 32'(pad_c[7:0]), 190);
        check("wrap_m256b", 32'(pad_c[15:8]), 188);
        dx_c = pack(10, 255);
        strobe();
        check("wrap_p10", 32'(pad_c[7:0]), 0);
        check("wrap_p255", 32'(pad_c[15:8]), 43);

        // dial: +3 gives pulses at +1, +5, +9
        dx_d = pack(3, 0);
        strobe();
        seen  = '0;
        other = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            seen[k] = pul_d[0];
            other   = other | pul_d[1];
        end
        check("dial_p3_pattern", 32'(seen), 32'h0222);
        check("dial_p3_dir", 32'(dir_d[0]), 1);
        check("dial_ch1_quiet", 32'(other), 0);
        check("dial_p3_pad", 32'(pad_d[7:0]), 103);

        dx_d = pack(-2, 0);
        strobe();
        seen = '0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            seen[k] = pul_d[0];
        end
        check("dial_m2_pattern", 32'(seen), 32'h0022);
        check("dial_m2_dir", 32'(dir_d[0]), 0);

        // two +40 strobes land while the gap counter is still running
        dx_d = pack(40, 0);
        strobe();
        dx_d = pack(40, 0);
        strobe();
        cnt = 0;
        neg = 0;
        for (int k = 0; k < 160; k++) begin
            tick();
            if (pul_d[0]) begin
                cnt++;
                if (!dir_d[0]) neg++;
            end
        end
        check("dial_sat_count", 32'(cnt), 31);
        check("dial_sat_negdir", 32'(neg), 0);
        check("dial_sat_pad", 32'(pad_d[7:0]), 181);

        // recentre beats a simultaneous strobe
        dx_d     = pack(50, 0);
        recentre = 1'b1;
        mouse_st = 1'b1;
        tick();
        recentre = 1'b0;
        mouse_st = 1'b0;
        dx_d     = '0;
        check("rc_pad_d", 32'(pad_d), 32'h6464);
        check("rc_pad_c", 32'(pad_c), 32'h6464);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (pul_d != 2'b00) cnt++;
        end
        check("rc_no_pulses", 32'(cnt), 0);

        // reset in the middle of a pulse train
        dx_d = pack(10, 0);
        strobe();
        check("mr_pad_before", 32'(pad_d[7:0]), 110);
        repeat (5) tick();
        check("mr_pulse_live", 32'(pul_d[0]), 1);
        rst_n = 1'b0;
        #1;
        check("mr_pulse_cut", 32'(pul_d), 0);
        check("mr_dir_cut", 32'(dir_d), 0);
        check("mr_pad_cut", 32'(pad_d[7:0]), 100);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (pul_d != 2'b00) cnt++;
        end
        check("mr_no_residual", 32'(cnt), 0);
        check("mr_pad_after", 32'(pad_d), 32'h6464);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jtframe_paddle_multi.md
Name: jtframe_paddle_multi

Overview:
Multi-channel mouse-to-paddle/dial converter, next generation of the single-channel paddle block. Each channel integrates a signed mouse delta into an absolute paddle position, with programmable sensitivity (fractional remainder kept), clamp or wrap-around mode, a recentre command, and an incremental dial pulse stream for games that read spinners as step/direction. Sits between the mouse decoder and the game input mux.

Parameters:
CH, 2, number of channels (ch0 = mouse X, ch1 = mouse Y), 1..4
DW, 9, signed mouse delta width per channel
PW, 8, paddle position width
PMAX, 255, maximum paddle value (< 2^PW)
CENTRE, 128, reset/recentre paddle value (<= PMAX)
SENS, 0, sensitivity divider as right shift 0..4 (delta / 2^SENS, floor)
WRAP, 0, 0 = clamp to [0,PMAX]; 1 = wrap modulo PMAX+1
PEND_W, 6, signed width of per-channel pending dial-step counter
GAP, 4, minimum cycles between consecutive dial pulses of one channel (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
mouse_dx  in  CH*DW  packed signed deltas, channel n at [n*DW +: DW]
mouse_st  in  1  one-cycle strobe: deltas valid
recentre  in  1  one-cycle command: all channels back to CENTRE
paddle  out  CH*PW  packed absolute positions, channel n at [n*PW +: PW]
dial_pulse  out  CH  one-cycle step pulse per channel
dial_dir  out  CH  direction of last/current pulse, 1 = positive

Behaviour:
- One clock, reset asynchronous active-low. Reset: paddle = CENTRE per channel, frac = 0, pending = 0, gap counters = 0, dial_pulse = 0, dial_dir = 0.
- Per channel on mouse_st: acc = frac + sext(dx) (DW+SENS+1 bits); step = acc >>> SENS (arithmetic, floor); frac <= acc[SENS-1:0] (nonnegative). SENS=0: step = dx, no frac.
- Position: nx = paddle + step, computed at PW+DW+2 signed bits (no internal overflow).
  - WRAP=0: nx<0 -> 0; nx>PMAX -> PMAX; else nx.
  - WRAP=1: nx reduced modulo PMAX+1 into [0,PMAX]; |step| may exceed PMAX+1 -> full modulo via bounded repeated subtract/add resolved in the same cycle (combinational, loop bounded by parameters).
- Latency: paddle updates on the clock edge that samples mouse_st (visible next cycle). No strobe -> hold.
- Dial: pending <= sat(pending + step) on mouse_st, saturating at +/-(2^(PEND_W-1)-1). Independent of clamp (pending counts raw step).
- Pulse engine per channel: if gap==0 and pending!=0 -> dial_pulse=1 for one cycle, dial_dir = (pending>0), pending moves one toward zero, gap <= GAP-1; else dial_pulse=0, gap decrements to 0. A strobe in the same cycle as a pulse: pending <= sat(pending + step -/+ 1).
- Pulses for one strobe are therefore spaced exactly GAP cycles; first pulse one cycle after the strobe edge if gap was 0.
- recentre: all channels paddle = CENTRE, frac = 0, pending = 0, gap = 0; pulse output 0 that cycle. Wins over simultaneous mouse_st (strobe discarded).
- Reset asserted mid pulse-train: outputs return to reset values immediately; no residual pulses after release.
- Channels fully independent except shared mouse_st/recentre.

Test Plan:
- Reset (CH=2, CENTRE=100, PMAX=200): rst_n low then high -> paddle = {100,100}, dial_pulse = 0, dial_dir = 0.
- SENS=2, ch0 dx=+3 strobed 3 times -> steps 0,1,1, frac 3,2,1, paddle0 = 102; ch1 dx=0 stays 100.
- Clamp (WRAP=0, SENS=0): dx=+255 strobed twice -> paddle0 = 200 and holds; dx=-256 -> 0; dx=-1 at 0 stays 0.
- Wrap (WRAP=1, SENS=0, PMAX=199, CENTRE=100): dx=+150 -> 50; then dx=-60 -> 190; dx=+10 -> 0.
- Dial (SENS=0, GAP=4): dx=+3 one strobe -> exactly 3 pulses, dial_dir=1, at cycles +1,+5,+9; then dx=-2 -> 2 pulses, dial_dir=0; dx=+40 twice with PEND_W=6 -> pending saturates at 31 -> 31 pulses.
- recentre same cycle as strobe dx=+50 -> paddle = 100, no pulses follow; rst_n low during pulse train -> pulses stop, paddle = CENTRE.
